// File: rtl/spa_pkg.sv
// Shared types and constants for the shortest-path edge entry front-end.
package spa_pkg;

    localparam int SPA_DATA_W = 4;

    typedef enum logic [1:0] {
        WAIT_SRC  = 2'd0,
        WAIT_DST  = 2'd1,
        WAIT_COST = 2'd2,
        PUSH      = 2'd3
    } entry_state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_VERTEX = 2'd1;
    localparam logic [1:0] ERR_SELF_LOOP  = 2'd2;
    localparam logic [1:0] ERR_SEQUENCE   = 2'd3;

    typedef struct packed {
        logic [SPA_DATA_W-1:0] src;
        logic [SPA_DATA_W-1:0] dst;
        logic [SPA_DATA_W-1:0] cost;
    } edge_rec_t;

    // Vertex ids are 1-based; zero and anything above the vertex count is illegal.
    function automatic logic vertex_ok(input logic [SPA_DATA_W-1:0] v, input int unsigned n);
        return (v != {SPA_DATA_W{1'b0}}) && (32'(v) <= n);
    endfunction

endpackage

// File: rtl/spa_button_conditioner.sv
// Raw button to single-cycle press: 2-FF synchroniser, debounce, one-shot with rearm.
module spa_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] hi_cnt_r;
    logic [CW-1:0] lo_cnt_r;
    logic          latched_r;
    logic          press_r;

    // Synchronise, count stable cycles per level, fire once and wait for a stable release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            hi_cnt_r  <= '0;
            lo_cnt_r  <= '0;
            latched_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
            if (sync2_r) begin
                lo_cnt_r <= '0;
                if (hi_cnt_r != CNT_MAX) begin
                    hi_cnt_r <= hi_cnt_r + CW'(1);
                end
            end else begin
                hi_cnt_r <= '0;
                if (lo_cnt_r != CNT_MAX) begin
                    lo_cnt_r <= lo_cnt_r + CW'(1);
                end
            end
            press_r <= !latched_r && (hi_cnt_r == CNT_MAX);
            if (!latched_r && (hi_cnt_r == CNT_MAX)) begin
                latched_r <= 1'b1;
            end else if (latched_r && (lo_cnt_r == CNT_MAX)) begin
                latched_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/spa_edge_entry.sv
// Switch/button edge entry: validates (src, dst, cost) triplets and queues them for the solver.
module spa_edge_entry
    import spa_pkg::*;
#(
    parameter int NUM_VERTICES    = 4,
    parameter int DATA_W          = SPA_DATA_W,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in0,
    input  logic                          in1,
    input  logic                          in2,
    input  logic                          in3,
    input  logic                          run_source,
    input  logic                          run_dest,
    input  logic                          run_cost,
    output logic                          edge_valid,
    input  logic                          edge_ready,
    output logic [DATA_W-1:0]             edge_src,
    output logic [DATA_W-1:0]             edge_dst,
    output logic [DATA_W-1:0]             edge_cost,
    output logic                          err_pulse,
    output logic [1:0]                    err_code,
    output logic [1:0]                    entry_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] sw1_r, sw2_r;
    logic              press_src_s, press_dst_s, press_cost_s;
    entry_state_t      state_r, state_nx_s;
    logic [DATA_W-1:0] src_r, dst_r, cost_r, src_nx_s, dst_nx_s, cost_nx_s;
    logic              seq_err_s, val_err_s, push_s, pop_s;
    logic [1:0]        val_code_s;
    logic              err_pulse_r;
    logic [1:0]        err_code_r;
    edge_rec_t         mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [AW:0]       count_r;
    edge_rec_t         head_s;

    // Two-stage synchroniser for the value switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw1_r <= '0;
            sw2_r <= '0;
        end else begin
            sw1_r <= {in3, in2, in1, in0};
            sw2_r <= sw1_r;
        end
    end

    spa_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_src (
        .clock(clock), .reset(reset), .button(run_source), .press(press_src_s));
    spa_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dst (
        .clock(clock), .reset(reset), .button(run_dest), .press(press_dst_s));
    spa_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cost (
        .clock(clock), .reset(reset), .button(run_cost), .press(press_cost_s));

    // Entry sequencing: act on the expected press only; any other press is a sequence error.
    always_comb begin
        state_nx_s = state_r;
        src_nx_s   = src_r;
        dst_nx_s   = dst_r;
        cost_nx_s  = cost_r;
        val_err_s  = 1'b0;
        val_code_s = ERR_NONE;
        push_s     = 1'b0;
        seq_err_s  = 1'b0;
        case (state_r)
            WAIT_SRC: begin
                seq_err_s = press_dst_s | press_cost_s;
                if (press_src_s) begin
                    if (vertex_ok(sw2_r, NUM_VERTICES)) begin
                        src_nx_s   = sw2_r;
                        state_nx_s = WAIT_DST;
                    end else begin
                        val_err_s  = 1'b1;
                        val_code_s = ERR_BAD_VERTEX;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            WAIT_DST: begin
                seq_err_s = press_src_s | press_cost_s;
                if (press_dst_s) begin
                    if (!vertex_ok(sw2_r, NUM_VERTICES)) begin
                        val_err_s  = 1'b1;
                        val_code_s = ERR_BAD_VERTEX;
                    end else if (sw2_r == src_r) begin
                        val_err_s  = 1'b1;
                        val_code_s = ERR_SELF_LOOP;
                    end else begin
                        dst_nx_s   = sw2_r;
                        state_nx_s = WAIT_COST;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            WAIT_COST: begin
                seq_err_s = press_src_s | press_dst_s;
                if (press_cost_s) begin
                    cost_nx_s  = sw2_r;
                    state_nx_s = PUSH;
                end else begin
                    state_nx_s = state_r;
                end
            end
            PUSH: begin
                seq_err_s = press_src_s | press_dst_s | press_cost_s;
                if (count_r < FULL_CNT) begin
                    push_s     = 1'b1;
                    state_nx_s = WAIT_SRC;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = WAIT_SRC;
            end
        endcase
    end

    // FSM, triplet latches and error reporting; SEQUENCE outranks value errors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= WAIT_SRC;
            src_r       <= '0;
            dst_r       <= '0;
            cost_r      <= '0;
            err_pulse_r <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            state_r     <= state_nx_s;
            src_r       <= src_nx_s;
            dst_r       <= dst_nx_s;
            cost_r      <= cost_nx_s;
            err_pulse_r <= seq_err_s | val_err_s;
            if (seq_err_s) begin
                err_code_r <= ERR_SEQUENCE;
            end else if (val_err_s) begin
                err_code_r <= val_code_s;
            end
        end
    end

    assign pop_s = (count_r != '0) && edge_ready;

    // First-word-fall-through FIFO; full is judged on the registered count only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= '{src: src_r, dst: dst_r, cost: cost_r};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign edge_valid  = (count_r != '0);
    assign edge_src    = head_s.src;
    assign edge_dst    = head_s.dst;
    assign edge_cost   = head_s.cost;
    assign err_pulse   = err_pulse_r;
    assign err_code    = err_code_r;
    assign entry_state = state_r;
    assign fifo_count  = count_r;

endmodule

// File: tb/tb_spa_edge_entry.sv
// Self-checking bench: directed scenarios plus random press/pop traffic against a transaction-level model.
module tb_spa_edge_entry;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       rs = 1'b0, rd = 1'b0, rc = 1'b0;
    logic       edge_ready = 1'b0;
    logic       edge_valid, err_pulse;
    logic [3:0] edge_src, edge_dst, edge_cost;
    logic [1:0] err_code, entry_state;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    typedef struct { int s; int d; int c; } rec_t;
    rec_t q[$];
    int m_state = 0, m_src = 0, m_dst = 0, m_cost = 0, m_code = 0, m_pulses = 0;

    spa_edge_entry dut (
        .clock(clock), .reset(reset),
        .in0(sw[0]), .in1(sw[1]), .in2(sw[2]), .in3(sw[3]),
        .run_source(rs), .run_dest(rd), .run_cost(rc),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_cost(edge_cost),
        .err_pulse(err_pulse), .err_code(err_code),
        .entry_state(entry_state), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (err_pulse === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_try_push();
        if (m_state == 3 && q.size() < 4) begin
            q.push_back('{m_src, m_dst, m_cost});
            m_state = 0;
        end
    endfunction

    // mask bit0 = source, bit1 = dest, bit2 = cost
    function automatic void m_press(input int mask, input int v);
        int  expect_bit;
        bit  seq;
        bit  verr;
        int  vcode;
        expect_bit = (m_state == 0) ? 1 : (m_state == 1) ? 2 : (m_state == 2) ? 4 : 0;
        seq   = (mask & ~expect_bit) != 0;
        verr  = 1'b0;
        vcode = 0;
        if ((mask & expect_bit) != 0) begin
            if (m_state == 0) begin
                if (v >= 1 && v <= 4) begin m_src = v; m_state = 1; end
                else begin verr = 1'b1; vcode = 1; end
            end else if (m_state == 1) begin
                if (v < 1 || v > 4) begin verr = 1'b1; vcode = 1; end
                else if (v == m_src) begin verr = 1'b1; vcode = 2; end
                else begin m_dst = v; m_state = 2; end
            end else begin
                m_cost = v; m_state = 3;
            end
        end
        if (seq) m_code = 3;
        else if (verr) m_code = vcode;
        m_pulses = (seq || verr) ? 1 : 0;
        m_try_push();
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".state"}, entry_state, m_state);
        check({tag, ".code"}, err_code, m_code);
        check({tag, ".count"}, fifo_count, q.size());
        check({tag, ".valid"}, edge_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check({tag, ".src"}, edge_src, q[0].s);
            check({tag, ".dst"}, edge_dst, q[0].d);
            check({tag, ".cost"}, edge_cost, q[0].c);
        end
    endtask

    // Hold the given buttons for len cycles, then leave a gap long enough to rearm.
    task automatic act(input string tag, input int mask, input int v, input int len);
        int p0;
        p0 = pulse_cnt;
        @(negedge clock);
        sw = 4'(v);
        {rc, rd, rs} = 3'(mask);
        repeat (len) @(negedge clock);
        {rc, rd, rs} = 3'b000;
        repeat (10) @(negedge clock);
        m_pulses = 0;
        if (len >= 4) m_press(mask, v);
        check({tag, ".pulses"}, pulse_cnt - p0, m_pulses);
        check_all(tag);
    endtask

    task automatic pop(input string tag);
        @(negedge clock);
        check({tag, ".pre_valid"}, edge_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check({tag, ".pre_src"}, edge_src, q[0].s);
            check({tag, ".pre_dst"}, edge_dst, q[0].d);
            check({tag, ".pre_cost"}, edge_cost, q[0].c);
        end
        edge_ready = 1'b1;
        @(negedge clock);
        edge_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        m_try_push();
        repeat (2) @(negedge clock);
        check_all(tag);
    endtask

    task automatic triplet(input string tag, input int s, input int d, input int c);
        act({tag, ".s"}, 1, s, 5);
        act({tag, ".d"}, 2, d, 5);
        act({tag, ".c"}, 4, c, 5);
    endtask

    initial begin
        int lat;
        int r, mask, v, len;

        repeat (3) @(negedge clock);
        check("rst.valid", edge_valid, 0);
        check("rst.count", fifo_count, 0);
        check("rst.state", entry_state, 0);
        check("rst.code", err_code, 0);
        check("rst.pulse", err_pulse, 0);
        check("rst.src", edge_src, 0);
        check("rst.dst", edge_dst, 0);
        check("rst.cost", edge_cost, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Test 1: triplet 1,3,3 with cost-press latency measured
        act("t1.s", 1, 1, 5);
        act("t1.d", 2, 3, 5);
        lat = 0;
        @(negedge clock);
        sw = 4'd3;
        rc = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (i == 5) rc = 1'b0;
            if (edge_valid === 1'b1 && lat == 0) lat = i;
        end
        check("t1.latency", lat, 9);
        m_press(4, 3);
        check_all("t1.rec");
        pop("t1.pop");

        // Test 2: short cost pulses are ignored, 4-cycle hold is accepted
        act("t2.s", 1, 2, 5);
        act("t2.d", 2, 1, 5);
        act("t2.c1", 4, 7, 1);
        act("t2.c2", 4, 7, 2);
        act("t2.c4", 4, 9, 4);

        // Test 3: bad vertices and self loop
        act("t3.s0", 1, 0, 5);
        act("t3.s5", 1, 5, 5);
        act("t3.s2", 1, 2, 5);
        act("t3.self", 2, 2, 5);
        act("t3.d4", 2, 4, 5);
        act("t3.c", 4, 15, 5);

        // Test 4: cost press while waiting for source
        act("t4.seq", 4, 3, 5);

        // Simultaneous presses: source acted on, dest flagged
        act("sim.sd", 3, 1, 5);
        act("sim.d", 2, 4, 5);
        act("sim.c", 4, 0, 5);

        // Test 5: drain, then overfill with five triplets
        while (q.size() != 0) pop("t5.drain");
        for (int k = 0; k < 5; k++) triplet("t5.fill", (k % 4) + 1, ((k + 1) % 4) + 1, k + 10);
        check("t5.full_state", entry_state, 3);
        act("t5.push_seq", 1, 1, 5);
        pop("t5.pop1");
        while (q.size() != 0) pop("t5.drain2");

        // Test 6: asynchronous reset mid-entry with records queued
        triplet("t6.a", 1, 2, 5);
        triplet("t6.b", 3, 4, 6);
        act("t6.s", 1, 2, 5);
        act("t6.d", 2, 4, 5);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t6.valid", edge_valid, 0);
        check("t6.count", fifo_count, 0);
        check("t6.state", entry_state, 0);
        check("t6.code", err_code, 0);
        q.delete();
        m_state = 0; m_code = 0;
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        triplet("t6.fresh", 4, 1, 8);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pop("rnd.pop");
            end else begin
                mask = (r < 8) ? (1 << $urandom_range(0, 2)) : $urandom_range(1, 7);
                v    = (mask == 4) ? $urandom_range(0, 15) : $urandom_range(0, 5);
                len  = (r == 2) ? $urandom_range(1, 3) : $urandom_range(4, 6);
                act("rnd.act", mask, v, len);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
